// File: rtl/dda_param_framer.sv
// Receive-side framer: assembles SYNC + 10 payload bytes + checksum into five
// 16-bit DDA parameters, committed atomically with a one-cycle valid pulse.
module dda_param_framer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 10417
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_error,
    output logic [15:0] ic1,
    output logic [15:0] ic2,
    output logic [15:0] vK_M,
    output logic [15:0] vD_M,
    output logic [15:0] dt,
    output logic        params_valid,
    output logic        busy,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic        err_frame
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Terminal check is made one count early so the abort lands on the edge
    // where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [CW-1:0] TERM_M1 = CW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

    state_t        state, state_next;
    logic [3:0]    idx;
    logic [7:0]    sum;
    logic [CW-1:0] cnt;
    logic [7:0]    shadow [10];

    logic do_start, do_store, do_commit, do_cksum_err, do_timeout, do_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next   = state;
        do_start     = 1'b0;
        do_store     = 1'b0;
        do_commit    = 1'b0;
        do_cksum_err = 1'b0;
        do_timeout   = 1'b0;
        do_frame_err = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    do_start   = 1'b1;
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (rx_error) begin
                    do_frame_err = 1'b1;
                    state_next   = IDLE;
                end else if (rx_valid) begin
                    do_store = 1'b1;
                    if (idx == 4'd9) state_next = CHECK;
                end else if (cnt == TERM_M1) begin
                    do_timeout = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                if (rx_error) begin
                    do_frame_err = 1'b1;
                    state_next   = IDLE;
                end else if (rx_valid) begin
                    do_commit    = (rx_byte == sum);
                    do_cksum_err = (rx_byte != sum);
                    state_next   = IDLE;
                end else if (cnt == TERM_M1) begin
                    do_timeout = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the shadow buffer is small and is cleared on reset so a stale frame can never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            sum          <= '0;
            cnt          <= '0;
            for (int i = 0; i < 10; i++) shadow[i] <= '0;
            ic1          <= '0;
            ic2          <= '0;
            vK_M         <= '0;
            vD_M         <= '0;
            dt           <= '0;
            params_valid <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_frame    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            params_valid <= do_commit;
            err_checksum <= do_cksum_err;
            err_timeout  <= do_timeout;
            err_frame    <= do_frame_err;

            if (state_next == IDLE || rx_valid) cnt <= '0;
            else                                cnt <= cnt + CW'(1);

            if (do_start) begin
                idx <= '0;
                sum <= '0;
            end
            if (do_store) begin
                shadow[idx] <= rx_byte;
                sum         <= sum + rx_byte;
                idx         <= idx + 4'd1;
            end
            if (do_commit) begin
                ic1  <= {shadow[0], shadow[1]};
                ic2  <= {shadow[2], shadow[3]};
                vK_M <= {shadow[4], shadow[5]};
                vD_M <= {shadow[6], shadow[7]};
                dt   <= {shadow[8], shadow[9]};
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dda_param_framer.sv
// Randomized bench for dda_param_framer: a frame-level scan of each byte stream
// predicts commits, checksum errors and busy, and tracks the committed parameters.
module tb_dda_param_framer;

    localparam int T = 40;

    typedef logic [7:0] byteq_t[$];
    typedef enum {EV_NONE, EV_COMMIT, EV_CKERR} ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_error;
    logic [15:0] ic1, ic2, vK_M, vD_M, dt;
    logic        params_valid, busy, err_checksum, err_timeout, err_frame;

    int          tests_run = 0;
    int          fails     = 0;
    logic [15:0] exp_p [5];

    always #5 clk = ~clk;

    dda_param_framer #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
        .ic1(ic1), .ic2(ic2), .vK_M(vK_M), .vD_M(vD_M), .dt(dt),
        .params_valid(params_valid), .busy(busy), .err_checksum(err_checksum),
        .err_timeout(err_timeout), .err_frame(err_frame)
    );

    function automatic logic [79:0] outs();
        return {ic1, ic2, vK_M, vD_M, dt};
    endfunction

    function automatic logic [79:0] exp_vec();
        return {exp_p[0], exp_p[1], exp_p[2], exp_p[3], exp_p[4]};
    endfunction

    function automatic logic [4:0] flags();
        return {params_valid, err_checksum, err_timeout, err_frame, busy};
    endfunction

    function automatic byteq_t make_frame(input logic [15:0] w0, w1, w2, w3, w4,
                                          input logic [7:0] ck_delta);
        byteq_t      q;
        logic [15:0] w [5];
        logic [7:0]  s;
        w = '{w0, w1, w2, w3, w4};
        s = 8'h00;
        q.push_back(8'hA5);
        for (int i = 0; i < 5; i++) begin
            q.push_back(w[i][15:8]);
            q.push_back(w[i][7:0]);
            s = s + w[i][15:8] + w[i][7:0];
        end
        q.push_back(s + ck_delta);
        return q;
    endfunction

    // Sends a byte stream starting from idle, with random idle gaps, checking
    // pulses, busy and parameters after every byte and every gap cycle.
    task automatic send_stream(input string name, input byteq_t q);
        int          n, i, gap;
        ev_t         ev [$];
        bit          bz [$];
        logic [79:0] pv [$];
        logic [7:0]  s;
        logic [4:0]  exp_f;
        n = q.size();
        for (int j = 0; j < n; j++) begin
            ev.push_back(EV_NONE);
            bz.push_back(1'b0);
            pv.push_back('0);
        end
        i = 0;
        while (i < n) begin
            if (q[i] != 8'hA5) begin
                i++;
            end else begin
                for (int k = 0; k <= 10; k++) if (i + k < n) bz[i + k] = 1'b1;
                if (i + 11 < n) begin
                    s = 8'h00;
                    for (int k = 1; k <= 10; k++) s = s + q[i + k];
                    ev[i + 11] = (s == q[i + 11]) ? EV_COMMIT : EV_CKERR;
                    for (int k = 1; k <= 10; k++) pv[i + 11][87 - 8*k -: 8] = q[i + k];
                end
                i += 12;
            end
        end
        for (int j = 0; j < n; j++) begin
            rx_valid = 1'b1;
            rx_byte  = q[j];
            @(negedge clk);
            rx_valid = 1'b0;
            if (ev[j] == EV_COMMIT)
                for (int w = 0; w < 5; w++) exp_p[w] = pv[j][79 - 16*w -: 16];
            exp_f = {ev[j] == EV_COMMIT, ev[j] == EV_CKERR, 1'b0, 1'b0, bz[j]};
            tests_run++;
            if (flags() !== exp_f) begin
                fails++;
                $display("FAIL %s byte %0d flags(pv,ck,to,fr,busy): got %b want %b", name, j, flags(), exp_f);
            end
            tests_run++;
            if (outs() !== exp_vec()) begin
                fails++;
                $display("FAIL %s byte %0d params: got %h want %h", name, j, outs(), exp_vec());
            end
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(negedge clk);
                tests_run++;
                if (flags() !== {4'b0000, bz[j]}) begin
                    fails++;
                    $display("FAIL %s gap after byte %0d flags: got %b want %b", name, j, flags(), {4'b0000, bz[j]});
                end
            end
        end
    endtask

    task automatic send_raw(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; rx_error = 1'b0;
        for (int w = 0; w < 5; w++) exp_p[w] = 16'h0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({outs(), flags()} !== 85'd0) begin
            fails++;
            $display("FAIL reset state: got %h/%b want 0", outs(), flags());
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        byteq_t q;
        q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h20, 8'h01, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01, 8'h37};
        send_stream("good_frame", q);
        tests_run++;
        if (outs() !== 80'h0010_0020_0100_0005_0001) begin
            fails++;
            $display("FAIL good_frame fixed values: got %h want 00100020010000050001", outs());
        end
    endtask

    task automatic test_checksum();
        byteq_t q;
        q = make_frame(16'h0010, 16'h0020, 16'h0100, 16'h0005, 16'h0001, 8'h01);
        q = {q, make_frame(16'h1234, 16'h0020, 16'h0100, 16'h0005, 16'h0001, 8'h00)};
        send_stream("checksum_then_retx", q);
        tests_run++;
        if (ic1 !== 16'h1234) begin
            fails++;
            $display("FAIL checksum retransmit ic1: got %h want 1234", ic1);
        end
    endtask

    task automatic test_leading_junk();
        byteq_t q;
        q = {8'h00, 8'hFF, 8'h3C};
        q = {q, make_frame(16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011, 16'h1213, 8'h00)};
        send_stream("leading_junk", q);
    endtask

    task automatic test_timeout();
        int n;
        int hit;
        send_raw(8'hA5);
        for (int k = 0; k < 3; k++) send_raw(8'($urandom));
        hit = -1;
        for (n = 1; n <= 2 * T; n++) begin
            @(negedge clk);
            if (err_timeout) begin
                hit = n;
                break;
            end
        end
        tests_run++;
        if (hit != T - 1) begin
            fails++;
            $display("FAIL timeout latency: got %0d cycles want %0d", hit, T - 1);
        end
        tests_run++;
        if ({busy, params_valid, outs()} !== {1'b0, 1'b0, exp_vec()}) begin
            fails++;
            $display("FAIL timeout aftermath busy/pv/params: got %b %b %h want 0 0 %h", busy, params_valid, outs(), exp_vec());
        end
        @(negedge clk);
        send_stream("after_timeout", make_frame(16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB, 8'h00));
    endtask

    task automatic test_sync_in_payload();
        send_stream("sync_as_data", make_frame(16'hA5A5, 16'(($urandom)), 16'h00A5, 16'(($urandom)), 16'hA500, 8'h00));
        tests_run++;
        if (ic1 !== 16'hA5A5) begin
            fails++;
            $display("FAIL sync_as_data ic1: got %h want a5a5", ic1);
        end
        send_raw(8'hA5);
        for (int k = 0; k < 4; k++) send_raw(8'($urandom));
        rx_error = 1'b1;
        send_raw(8'($urandom));
        rx_error = 1'b0;
        tests_run++;
        if ({flags(), outs()} !== {5'b00010, exp_vec()}) begin
            fails++;
            $display("FAIL rx_error flags/params: got %b %h want 00010 %h", flags(), outs(), exp_vec());
        end
        @(negedge clk);
        tests_run++;
        if (flags() !== 5'b00000) begin
            fails++;
            $display("FAIL rx_error pulse width: got %b want 00000", flags());
        end
    endtask

    task automatic test_random();
        byteq_t q;
        logic [7:0] d;
        logic [7:0] j;
        for (int f = 0; f < 8; f++) begin
            q = {};
            repeat ($urandom_range(0, 3)) begin
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h5A;
                q.push_back(j);
            end
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            q = {q, make_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), d)};
            send_stream("random", q);
        end
    endtask

    task automatic test_reset_mid();
        send_stream("pre_reset", make_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 8'h00));
        send_raw(8'hA5);
        for (int k = 0; k < 3; k++) send_raw(8'($urandom));
        #1 rst = 1'b1;
        #1;
        for (int w = 0; w < 5; w++) exp_p[w] = 16'h0;
        tests_run++;
        if ({outs(), flags()} !== 85'd0) begin
            fails++;
            $display("FAIL async mid-frame reset: got %h/%b want 0", outs(), flags());
        end
        #1 rst = 1'b0;
        @(negedge clk);
        send_stream("post_reset", make_frame(16'hCAFE, 16'hBEEF, 16'h0123, 16'h4567, 16'h89AB, 8'h00));
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_checksum();
        test_leading_junk();
        test_timeout();
        test_sync_in_payload();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/dda_param_framer.md
Name: dda_param_framer

Overview:
- Receive-side framing stage between the UART byte receiver and the DDA core.
- Consumes the received-byte strobe stream and assembles framed, checksummed parameter packets.
- Presents the five 16-bit DDA parameters (ic1, ic2, vK_M, vD_M, dt) atomically, with a one-cycle valid pulse.
- Rejects malformed, corrupted or stalled frames without disturbing the last good parameter set.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 10417, max idle clocks between bytes inside a frame (2 byte-times at 9600 baud, 5 MHz); must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_valid  in  1  one-cycle strobe: rx_byte is valid (UART "received").
- rx_byte  in  8  received byte.
- rx_error  in  1  one-cycle strobe: UART receive/framing error.
- ic1  out  16  initial condition, state 1.
- ic2  out  16  initial condition, state 2.
- vK_M  out  16  K/M coefficient.
- vD_M  out  16  D/M coefficient.
- dt  out  16  integration step.
- params_valid  out  1  one-cycle pulse: a new parameter set has been committed.
- busy  out  1  high while a frame is in progress (state != IDLE).
- err_checksum  out  1  one-cycle pulse: checksum mismatch.
- err_timeout  out  1  one-cycle pulse: inter-byte timeout.
- err_frame  out  1  one-cycle pulse: rx_error seen during a frame.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE; all five parameter outputs=0; params_valid, busy and all err_* = 0; byte index, running sum, timeout counter and shadow buffer cleared.
- Frame format: SYNC_BYTE, then 10 payload bytes, then 1 checksum byte.
  - Payload order: ic1, ic2, vK_M, vD_M, dt. Each word big-endian (high byte first).
  - Checksum: 8-bit modulo-256 sum of the 10 payload bytes. The sync byte is excluded.
- State IDLE:
  - rx_valid with rx_byte==SYNC_BYTE -> PAYLOAD; index=0, sum=0, timeout counter=0.
  - Any other byte is ignored.
  - rx_error is ignored.
- State PAYLOAD:
  - Each rx_valid stores rx_byte into shadow[index], adds it to sum, increments index, and clears the timeout counter.
  - On the 10th byte (index 9) -> CHECK.
  - A byte equal to SYNC_BYTE is treated as data; there is no resync.
- State CHECK:
  - rx_valid with rx_byte==sum: copy shadow to the parameter outputs at that clock edge; params_valid=1 for the next cycle only; -> IDLE.
  - Mismatch: err_checksum pulses one cycle; outputs unchanged; -> IDLE.
- Timeout (PAYLOAD/CHECK only):
  - The counter increments every cycle without rx_valid.
  - On reaching TIMEOUT_CYCLES-1: err_timeout pulses; -> IDLE; outputs unchanged.
  - The counter is held at 0 in IDLE.
- rx_error in PAYLOAD/CHECK: err_frame pulses; -> IDLE; any rx_valid in the same cycle is discarded.
- Simultaneous events:
  - rx_valid and the timeout terminal count in the same cycle: the byte wins and the counter clears.
  - rx_error has priority over rx_valid.
- Parameter outputs change only on a successful commit and are held otherwise. No partial updates.
- Latency: checksum byte sampled at edge k -> outputs updated at edge k, params_valid high from edge k to edge k+1.
- At most one err_* pulse per frame. err_* and params_valid are mutually exclusive.
- Reset asserted mid-frame aborts immediately; outputs go to 0 asynchronously.

Test Plan:
1. Good frame: A5,00,10,00,20,01,00,00,05,00,01,37 -> ic1=0x0010, ic2=0x0020, vK_M=0x0100, vD_M=0x0005, dt=0x0001; params_valid exactly one cycle after the checksum strobe; busy low afterwards.
2. Same frame with checksum 38 -> err_checksum one pulse; outputs keep their previous values; an immediate retransmit with 37 commits.
3. Bytes 00,FF,3C then a good frame -> leading bytes ignored (busy stays 0 until A5); frame commits.
4. A5 then 3 payload bytes, then silence -> err_timeout pulses TIMEOUT_CYCLES-1 cycles after the last rx_valid; busy drops; the next good frame commits.
5. Payload containing A5 as data (ic1=0xA5A5, checksum adjusted) -> committed correctly. rx_error on the 5th payload byte -> err_frame pulse; no commit.
6. Assert rst mid-payload after a prior commit -> all outputs 0 without a clock edge; state IDLE; the following good frame commits normally.
